// File: rtl/window_read_sequencer_if.sv
// Handshake and geometry bundle between the datapath controller, the
// window read sequencer and the buffer read port / MAC stage.
interface window_read_sequencer_if #(
   parameter int DEPTH = 64,
   parameter int LW    = 8
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic          start;
   logic [AW-1:0] base;
   logic [AW-1:0] stride;
   logic [LW-1:0] win_len;
   logic [LW-1:0] num_win;
   logic          out_ready;
   logic [AW-1:0] addr;
   logic          addr_valid;
   logic          win_last;
   logic          busy;
   logic          done;

   // controller / consumer side
   modport master (
      output start, base, stride, win_len, num_win, out_ready,
      input  addr, addr_valid, win_last, busy, done
   );

   // sequencer side
   modport slave (
      input  start, base, stride, win_len, num_win, out_ready,
      output addr, addr_valid, win_last, busy, done
   );
endinterface

// File: rtl/window_read_sequencer.sv
// Read-address generator for a circular sample buffer: num_win windows of
// win_len consecutive addresses, window starts stride apart, all mod DEPTH.
//
// state  | meaning
// S_IDLE | waiting for start, addr_valid low
// S_RUN  | issuing addresses over the valid/ready handshake
// S_DONE | one-cycle done pulse, then back to S_IDLE
module window_read_sequencer #(
   parameter int  DEPTH = 64,
   parameter int  LW    = 8,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input logic                   clk,
   input logic                   rst,
   window_read_sequencer_if.slave bus
);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        state;
   logic [LW-1:0] k;
   logic [LW-1:0] w;
   logic [LW-1:0] len_m1;
   logic [LW-1:0] nwin_m1;
   logic [AW-1:0] ws;
   logic [AW-1:0] stride_q;
   logic [AW-1:0] addr_q;
   logic          valid_q;
   logic          last_q;
   logic          busy_q;
   logic          done_q;

   // Both operands are below DEPTH, so one conditional subtract is enough
   // even when DEPTH is not a power of two.
   function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                             input logic [AW-1:0] b);
      logic [AW:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= DEPTH_W) sum = sum - DEPTH_W;
      return sum[AW-1:0];
   endfunction

   // Sequencer FSM with position/window counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         k        <= '0;
         w        <= '0;
         len_m1   <= '0;
         nwin_m1  <= '0;
         ws       <= '0;
         stride_q <= '0;
         addr_q   <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  len_m1   <= bus.win_len - LW'(1);
                  nwin_m1  <= bus.num_win - LW'(1);
                  stride_q <= bus.stride;
                  ws       <= bus.base;
                  addr_q   <= bus.base;
                  k        <= '0;
                  w        <= '0;
                  busy_q   <= 1'b1;
                  if (bus.win_len == '0 || bus.num_win == '0) begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state   <= S_RUN;
                     valid_q <= 1'b1;
                     last_q  <= (bus.win_len == LW'(1));
                  end
               end
            end
            S_RUN: begin
               if (bus.out_ready) begin
                  if (k != len_m1) begin
                     k      <= k + LW'(1);
                     addr_q <= mod_add(addr_q, AW'(1));
                     last_q <= ((k + LW'(1)) == len_m1);
                  end else if (w != nwin_m1) begin
                     k      <= '0;
                     w      <= w + LW'(1);
                     ws     <= mod_add(ws, stride_q);
                     addr_q <= mod_add(ws, stride_q);
                     last_q <= (len_m1 == '0);
                  end else begin
                     state   <= S_DONE;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: begin
               state   <= S_IDLE;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.addr       = addr_q;
   assign bus.addr_valid = valid_q;
   assign bus.win_last   = last_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_window_read_sequencer.sv
// Bench for window_read_sequencer: two instances (DEPTH 64 and 48) sharing
// stimulus; expected address/win_last pairs come from a reference model
// pushed into a queue and popped on every transfer.
module tb_window_read_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       start = 1'b0;
   logic       ready = 1'b0;
   logic       sel48 = 1'b0;
   logic [5:0] base_v = '0;
   logic [5:0] stride_v = '0;
   logic [7:0] len_v = '0;
   logic [7:0] nwin_v = '0;

   window_read_sequencer_if #(.DEPTH(64), .LW(8)) if64 ();
   window_read_sequencer_if #(.DEPTH(48), .LW(8)) if48 ();

   assign if64.start     = start & ~sel48;
   assign if64.base      = base_v;
   assign if64.stride    = stride_v;
   assign if64.win_len   = len_v;
   assign if64.num_win   = nwin_v;
   assign if64.out_ready = ready;
   assign if48.start     = start & sel48;
   assign if48.base      = base_v;
   assign if48.stride    = stride_v;
   assign if48.win_len   = len_v;
   assign if48.num_win   = nwin_v;
   assign if48.out_ready = ready;

   window_read_sequencer #(.DEPTH(64), .LW(8)) dut64 (.clk(clk), .rst(rst), .bus(if64));
   window_read_sequencer #(.DEPTH(48), .LW(8)) dut48 (.clk(clk), .rst(rst), .bus(if48));

   wire [5:0] m_addr  = sel48 ? if48.addr       : if64.addr;
   wire       m_valid = sel48 ? if48.addr_valid : if64.addr_valid;
   wire       m_last  = sel48 ? if48.win_last   : if64.win_last;
   wire       m_busy  = sel48 ? if48.busy       : if64.busy;
   wire       m_done  = sel48 ? if48.done       : if64.done;

   typedef struct packed {
      logic [5:0] addr;
      logic       last;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model: full expected sequence for one run.
   task automatic push_exp(input int b, input int s, input int len, input int nw, input int depth);
      exp_t e;
      for (int wi = 0; wi < nw; wi++)
         for (int ki = 0; ki < len; ki++) begin
            e.addr = 6'((b + wi * s + ki) % depth);
            e.last = (ki == len - 1);
            exp_q.push_back(e);
         end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({if64.addr, if64.addr_valid, if64.win_last, if64.busy, if64.done} !== 10'b0) begin
         failures++;
         $display("FAIL reset64 outputs got=%b exp=0", {if64.addr, if64.addr_valid, if64.win_last, if64.busy, if64.done});
      end
      checks++;
      if ({if48.addr, if48.addr_valid, if48.win_last, if48.busy, if48.done} !== 10'b0) begin
         failures++;
         $display("FAIL reset48 outputs got=%b exp=0", {if48.addr, if48.addr_valid, if48.win_last, if48.busy, if48.done});
      end
      rst = 1'b0;
   endtask

   // One full run with scoreboard checking, optional backpressure and an
   // optional start pulse injected mid-run.
   task automatic test_run(input string name, input bit s48, input int b, input int s,
                           input int len, input int nw, input bit bp, input bit poke);
      int         n;
      bit         seen;
      bit         prev_stall;
      logic [5:0] prev_a;
      logic       prev_l;
      exp_t       e;
      @(negedge clk);
      sel48 = s48;
      base_v = 6'(b);
      stride_v = 6'(s);
      len_v = 8'(len);
      nwin_v = 8'(nw);
      ready = 1'b1;
      start = 1'b1;
      push_exp(b, s, len, nw, s48 ? 48 : 64);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (m_busy !== 1'b1 || m_valid !== 1'b1 || m_addr !== 6'(b)) begin
         failures++;
         $display("FAIL %s first_cycle got busy=%b valid=%b addr=%0d exp busy=1 valid=1 addr=%0d",
                  name, m_busy, m_valid, m_addr, b);
      end
      n = 0;
      seen = 1'b0;
      prev_stall = 1'b0;
      prev_a = '0;
      prev_l = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         if (poke && c == 2) begin
            start = 1'b1;
            base_v = 6'd30;
         end else begin
            start = 1'b0;
         end
         ready = bp ? (c % 3 == 0) : 1'b1;
         if (prev_stall) begin
            checks++;
            if (m_addr !== prev_a || m_last !== prev_l) begin
               failures++;
               $display("FAIL %s stall_hold got addr=%0d last=%b exp addr=%0d last=%b",
                        name, m_addr, m_last, prev_a, prev_l);
            end
         end
         if (m_done) begin
            seen = 1'b1;
            checks++;
            if (n !== len * nw || m_valid !== 1'b0 || m_busy !== 1'b1 || exp_q.size() != 0) begin
               failures++;
               $display("FAIL %s done_state got xfers=%0d valid=%b busy=%b left=%0d exp xfers=%0d valid=0 busy=1 left=0",
                        name, n, m_valid, m_busy, exp_q.size(), len * nw);
            end
         end else if (m_valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL %s extra_xfer got addr=%0d exp none", name, m_addr);
            end else begin
               e = exp_q.pop_front();
               if (m_addr !== e.addr || m_last !== e.last) begin
                  failures++;
                  $display("FAIL %s xfer%0d got addr=%0d last=%b exp addr=%0d last=%b",
                           name, n, m_addr, m_last, e.addr, e.last);
               end
            end
            n++;
         end
         prev_stall = m_valid && !ready;
         prev_a = m_addr;
         prev_l = m_last;
         if (!seen) @(negedge clk);
      end
      start = 1'b0;
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s timeout got no done exp done after %0d xfers", name, len * nw);
      end
      @(negedge clk);
      checks++;
      if (m_done !== 1'b0 || m_busy !== 1'b0 || m_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s back_to_idle got done=%b busy=%b valid=%b exp 0 0 0", name, m_done, m_busy, m_valid);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (m_valid !== 1'b0 || m_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s stays_idle got valid=%b busy=%b exp 0 0", name, m_valid, m_busy);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_zero_len();
      int lens[2];
      int nws[2];
      lens[0] = 0; nws[0] = 5;
      lens[1] = 3; nws[1] = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         sel48 = 1'b0;
         base_v = 6'd7;
         stride_v = 6'd1;
         len_v = 8'(lens[i]);
         nwin_v = 8'(nws[i]);
         ready = 1'b1;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         checks++;
         if (m_done !== 1'b1 || m_valid !== 1'b0 || m_busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_len%0d pulse got done=%b valid=%b busy=%b exp 1 0 1", i, m_done, m_valid, m_busy);
         end
         @(negedge clk);
         checks++;
         if (m_done !== 1'b0 || m_valid !== 1'b0 || m_busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_len%0d after got done=%b valid=%b busy=%b exp 0 0 0", i, m_done, m_valid, m_busy);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      int   n;
      exp_t e;
      @(negedge clk);
      sel48 = 1'b0;
      base_v = 6'd10;
      stride_v = 6'd4;
      len_v = 8'd3;
      nwin_v = 8'd2;
      ready = 1'b1;
      start = 1'b1;
      push_exp(10, 4, 3, 2, 64);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      for (int c = 0; c < 50 && n < 3; c++) begin
         if (m_valid && ready) begin
            e = exp_q.pop_front();
            checks++;
            if (m_addr !== e.addr) begin
               failures++;
               $display("FAIL rst_mid xfer%0d got addr=%0d exp addr=%0d", n, m_addr, e.addr);
            end
            n++;
         end
         if (n < 3) @(negedge clk);
      end
      if (n < 3) begin
         checks++;
         failures++;
         $display("FAIL rst_mid timeout got xfers=%0d exp 3", n);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || m_busy !== 1'b0 || m_addr !== 6'd0 || m_last !== 1'b0 || m_done !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid outputs got valid=%b busy=%b addr=%0d last=%b done=%b exp all 0",
                  m_valid, m_busy, m_addr, m_last, m_done);
      end
      rst = 1'b0;
      exp_q.delete();
      test_run("restart", 1'b0, 10, 4, 3, 2, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_run("basic", 1'b0, 10, 4, 3, 2, 1'b0, 1'b0);
      test_run("wrap48", 1'b1, 46, 5, 4, 2, 1'b0, 1'b0);
      test_run("backpressure", 1'b0, 10, 4, 3, 2, 1'b1, 1'b0);
      test_zero_len();
      test_run("start_busy", 1'b0, 10, 4, 3, 2, 1'b0, 1'b1);
      test_run("overlap", 1'b0, 60, 2, 5, 3, 1'b1, 1'b0);
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
